// File: rtl/dsram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data SRAM.
// Carries m0/m1 request/response channels plus the SRAM pin group.
interface dsram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              m0_req;
    logic              m0_wr;
    logic [3:0]        m0_wstrb;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_wr;
    logic [3:0]        m1_wstrb;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              data_sram_en;
    logic [3:0]        data_sram_we;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;

    modport slave (
        input  m0_req, m0_wr, m0_wstrb, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output data_sram_en, data_sram_we,
        output data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport master (
        output m0_req, m0_wr, m0_wstrb, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  data_sram_en, data_sram_we,
        input  data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/dsram_arbiter.sv
// Data SRAM arbiter: CPU port (m0) and debug/DMA port (m1) share one SRAM.
// Ports: clk, resetn (async active-low), bus (dsram_arbiter_if.slave).
// Grant is combinational, read data returns to its owner one cycle later.
// Port 1 is force-granted after STARVE_MAX consecutive losing cycles.
// Option: define DSRAM_ARB_RR_EN for round-robin; default is m0 priority.
module dsram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 7
) (
    input logic           clk,
    input logic           resetn,
    dsram_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       rd_pend;
    logic       rd_owner;
    logic [3:0] starve_cnt;
    logic       force1;
    logic       gnt0;
    logic       gnt1;
    logic       rd_go;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_we;

    assign force1 = bus.m1_req && (starve_cnt == STARVE_LIM);

`ifdef DSRAM_ARB_RR_EN
    logic last_gnt;
    // On conflict the port that did not win last time goes next.
    assign gnt1 = bus.m1_req &
                  (~bus.m0_req | force1 | ~last_gnt);
`else
    assign gnt1 = bus.m1_req & (~bus.m0_req | force1);
`endif

    assign gnt0 = bus.m0_req & ~gnt1;

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 4'h0;
        unique case (1'b1)
            gnt0: begin
                sel_addr  = bus.m0_addr;
                sel_wdata = bus.m0_wdata;
                sel_we    = bus.m0_wr ? bus.m0_wstrb : 4'h0;
            end
            gnt1: begin
                sel_addr  = bus.m1_addr;
                sel_wdata = bus.m1_wdata;
                sel_we    = bus.m1_wr ? bus.m1_wstrb : 4'h0;
            end
            default: begin
            end
        endcase
    end

    assign bus.data_sram_en    = gnt0 | gnt1;
    assign bus.data_sram_we    = sel_we;
    assign bus.data_sram_addr  = sel_addr;
    assign bus.data_sram_wdata = sel_wdata;

    assign rd_go = (gnt0 & ~bus.m0_wr) | (gnt1 & ~bus.m1_wr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            rd_pend <= rd_go;
            if (rd_go) begin
                rd_owner <= gnt1;
            end
            if (bus.m1_req & ~gnt1) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

`ifdef DSRAM_ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt <= 1'b1;
        end else if (gnt0 | gnt1) begin
            last_gnt <= gnt1;
        end
    end
`endif

    assign bus.m0_rvalid = rd_pend & ~rd_owner;
    assign bus.m1_rvalid = rd_pend & rd_owner;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.data_sram_rdata : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.data_sram_rdata : '0;
endmodule

// File: tb/tb_dsram_arbiter.sv
// Self-checking bench for dsram_arbiter with a behavioural SRAM.
// Read responses are checked against a scoreboard queue every cycle.
module tb_dsram_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dsram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dsram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(7)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];
    logic [31:0] sram_rdata_r = 32'h0;

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 32'h40) return 32'h11223344;
        if (i == 32'h80) return 32'h0;
        return {b, 8'hA5, ~b, 8'h5A};
    endfunction

    // behavioural single-port SRAM, one-cycle read latency
    assign bus.data_sram_rdata = sram_rdata_r;
    always @(posedge clk) begin
        if (bus.data_sram_en) begin
            if (bus.data_sram_we == 4'h0) begin
                sram_rdata_r <= mem[bus.data_sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.data_sram_we[b])
                        mem[bus.data_sram_addr[9:2]][b*8 +: 8]
                            <= bus.data_sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic        e0, e1;
    logic [31:0] d0, d1;
    always @(negedge clk) begin
        e0 = 1'b0; e1 = 1'b0; d0 = 32'h0; d1 = 32'h0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].port) begin e1 = 1'b1; d1 = q[0].data; end
            else begin e0 = 1'b1; d0 = q[0].data; end
            void'(q.pop_front());
        end
        checks++;
        if (bus.m0_rvalid !== e0 || bus.m0_rdata !== d0) begin
            failures++;
            $display("FAIL rsp0 cyc=%0d got v=%b d=%h exp v=%b d=%h",
                     cyc, bus.m0_rvalid, bus.m0_rdata, e0, d0);
        end
        checks++;
        if (bus.m1_rvalid !== e1 || bus.m1_rdata !== d1) begin
            failures++;
            $display("FAIL rsp1 cyc=%0d got v=%b d=%h exp v=%b d=%h",
                     cyc, bus.m1_rvalid, bus.m1_rdata, e1, d1);
        end
    end

    task automatic drive0(bit req, bit wr, logic [3:0] st,
                          logic [31:0] a, logic [31:0] d);
        bus.m0_req = req; bus.m0_wr = wr; bus.m0_wstrb = st;
        bus.m0_addr = a; bus.m0_wdata = d;
    endtask

    task automatic drive1(bit req, bit wr, logic [3:0] st,
                          logic [31:0] a, logic [31:0] d);
        bus.m1_req = req; bus.m1_wr = wr; bus.m1_wstrb = st;
        bus.m1_addr = a; bus.m1_wdata = d;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive0(0, 0, 4'h0, 32'h0, 32'h0);
            drive1(0, 0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.data_sram_en,
             bus.data_sram_we} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctl got %b%b%b %b exp 000 0000",
                     bus.m0_gnt, bus.m1_gnt, bus.data_sram_en,
                     bus.data_sram_we);
        end
        checks++;
        if (bus.data_sram_addr !== 32'h0 ||
            bus.data_sram_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got a=%h d=%h exp 0",
                     bus.data_sram_addr, bus.data_sram_wdata);
        end
        #1;
        drive1(1, 0, 4'h0, 32'h104, 32'h0);
        #1;
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.data_sram_en} !== 3'b011) begin
            failures++;
            $display("FAIL reset_comb got %b%b%b exp 011",
                     bus.m0_gnt, bus.m1_gnt, bus.data_sram_en);
        end
        @(posedge clk); #1;
        drive1(0, 0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        drive0(1, 0, 4'hF, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.data_sram_en,
             bus.data_sram_we} !== 7'b1010000) begin
            failures++;
            $display("FAIL single_ctl got %b%b%b we=%b exp 101 we=0000",
                     bus.m0_gnt, bus.m1_gnt, bus.data_sram_en,
                     bus.data_sram_we);
        end
        checks++;
        if (bus.data_sram_addr !== 32'h100) begin
            failures++;
            $display("FAIL single_addr got %h exp 100",
                     bus.data_sram_addr);
        end
        q.push_back('{0, 32'h11223344, cyc + 1});
        idle(2);
    endtask

    task automatic test_byte_store();
        @(posedge clk); #1;
        drive1(1, 1, 4'b0100, 32'h200, 32'hAABBCCDD);
        @(negedge clk);
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.data_sram_en,
             bus.data_sram_we} !== 7'b0110100) begin
            failures++;
            $display("FAIL store_ctl got %b%b%b we=%b exp 011 we=0100",
                     bus.m0_gnt, bus.m1_gnt, bus.data_sram_en,
                     bus.data_sram_we);
        end
        checks++;
        if (bus.data_sram_addr !== 32'h200 ||
            bus.data_sram_wdata !== 32'hAABBCCDD) begin
            failures++;
            $display("FAIL store_bus got a=%h d=%h exp 200 aabbccdd",
                     bus.data_sram_addr, bus.data_sram_wdata);
        end
        ref_mem[32'h80][23:16] = 8'hBB;
        idle(3);
        @(posedge clk); #1;
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(1, 0, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.m1_gnt !== 1'b1) begin
            failures++;
            $display("FAIL store_rb_gnt got %b exp 1", bus.m1_gnt);
        end
        q.push_back('{1, ref_mem[32'h80], cyc + 1});
        idle(2);
    endtask

    task automatic test_conflict(int n, string nm);
        bit x1;
        do_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive0(1, 0, 4'h0, 32'h300, 32'h0);
            drive1(1, 0, 4'h0, 32'h304, 32'h0);
            @(negedge clk);
`ifdef DSRAM_ARB_RR_EN
            x1 = (i % 2) == 1;
`else
            x1 = (i % 8) == 7;
`endif
            checks++;
            if ({bus.m0_gnt, bus.m1_gnt} !== {~x1, x1} ||
                bus.data_sram_addr !== (x1 ? 32'h304 : 32'h300)) begin
                failures++;
                $display("FAIL %s i=%0d got g=%b%b a=%h exp g=%b%b",
                         nm, i, bus.m0_gnt, bus.m1_gnt,
                         bus.data_sram_addr, ~x1, x1);
            end
            q.push_back('{x1, x1 ? ref_mem[32'hC1] : ref_mem[32'hC0],
                          cyc + 1});
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(posedge clk); #1;
        drive0(1, 0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.m0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midrst_gnt got %b exp 1", bus.m0_gnt);
        end
        @(posedge clk); #1;
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);
        @(posedge clk); #1;
        drive0(1, 0, 4'h0, 32'h104, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.m0_gnt !== 1'b1 || bus.data_sram_addr !== 32'h104) begin
            failures++;
            $display("FAIL midrst_next got g=%b a=%h exp 1 104",
                     bus.m0_gnt, bus.data_sram_addr);
        end
        q.push_back('{0, ref_mem[32'h41], cyc + 1});
        idle(2);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        drive0(1, 0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.m0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL b2b_g0 got %b exp 1", bus.m0_gnt);
        end
        q.push_back('{0, ref_mem[32'h40], cyc + 1});
        @(posedge clk); #1;
        drive0(0, 0, 4'h0, 32'h0, 32'h0);
        drive1(1, 0, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_g1 got %b%b exp 01",
                     bus.m0_gnt, bus.m1_gnt);
        end
        q.push_back('{1, ref_mem[32'h80], cyc + 1});
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        test_reset();
        test_single_read();
        test_byte_store();
        test_conflict(4, "conflict");
        test_conflict(16, "starve");
        test_reset_mid_read();
        test_back_to_back();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got %0d exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
